// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD digit types, constants and next-state function
package bcd_pkg;
    localparam int BCD_WIDTH = 4;
    typedef logic [BCD_WIDTH-1:0] bcd_digit_t;
    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam bcd_digit_t BCD_ZERO = 4'd0;
    // Any code at or above the terminal count (including illegal codes 10..15) returns to zero
    function automatic bcd_digit_t bcd_next(input bcd_digit_t d, input bcd_digit_t max = BCD_MAX);
        return (d >= max) ? BCD_ZERO : bcd_digit_t'(d + 4'd1);
    endfunction
endpackage

// File: rtl/bcd_counter.sv
// bcd_counter: free-running single-digit BCD up-counter, 0..MAX_COUNT then wrap
// CLK_in  - clock, rising edge
// RESET   - synchronous active-high reset, forces count to 0
// BCD_out - current count, driven straight from the register
module bcd_counter
    import bcd_pkg::*;
#(
    parameter int BCD_WIDTH = 4,
    parameter int MAX_COUNT = 9
) (
    input  logic                 CLK_in,
    input  logic                 RESET,
    output logic [BCD_WIDTH-1:0] BCD_out
);
    bcd_digit_t count;
    always_ff @(posedge CLK_in)
        count <= RESET ? BCD_ZERO : bcd_next(count, bcd_digit_t'(MAX_COUNT));
    assign BCD_out = count;
endmodule

// File: tb/tb_bcd_counter.sv
// tb_bcd_counter: directed self-checking bench for bcd_counter
module tb_bcd_counter;
    logic       CLK_in = 1'b0;
    logic       RESET = 1'b0;
    logic [3:0] BCD_out;
    int tests = 0;
    int fails = 0;

    bcd_counter dut (.CLK_in(CLK_in), .RESET(RESET), .BCD_out(BCD_out));

    always #10 CLK_in = ~CLK_in;

    task automatic edge_sample();
        @(posedge CLK_in);
        #1;
    endtask

    task automatic chk(input string name, input logic [3:0] exp);
        tests++;
        if (BCD_out !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, BCD_out, exp, $time);
        end
    endtask

    task automatic test_reset();
        @(negedge CLK_in);
        RESET = 1'b1;
        edge_sample();
        chk("reset_edge", 4'd0);
        @(negedge CLK_in);
        RESET = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            edge_sample();
            chk("count_after_reset", 4'(i % 10));
        end
    endtask

    task automatic test_wraps();
        @(negedge CLK_in);
        RESET = 1'b1;
        edge_sample();
        chk("wrap_start", 4'd0);
        @(negedge CLK_in);
        RESET = 1'b0;
        for (int i = 1; i <= 35; i++) begin
            edge_sample();
            tests++;
            if (BCD_out > 4'd9 || $isunknown(BCD_out)) begin
                fails++;
                $display("FAIL wrap_range: got %0d expected <=9 at edge %0d", BCD_out, i);
            end
        end
        chk("wrap_35_edges", 4'd5);
    endtask

    task automatic test_mid_reset();
        @(negedge CLK_in);
        RESET = 1'b1;
        edge_sample();
        @(negedge CLK_in);
        RESET = 1'b0;
        repeat (7) edge_sample();
        chk("mid_reach_7", 4'd7);
        @(negedge CLK_in);
        RESET = 1'b1;
        edge_sample();
        chk("mid_reset_edge", 4'd0);
        @(negedge CLK_in);
        RESET = 1'b0;
        edge_sample();
        chk("mid_resume", 4'd1);
    endtask

    task automatic test_short_pulse();
        @(negedge CLK_in);
        RESET = 1'b1;
        edge_sample();
        @(negedge CLK_in);
        RESET = 1'b0;
        repeat (4) edge_sample();
        chk("pulse_reach_4", 4'd4);
        #2 RESET = 1'b1;
        #10 RESET = 1'b0;
        chk("pulse_between_edges", 4'd4);
        edge_sample();
        chk("pulse_ignored", 4'd5);
    endtask

    task automatic test_held_reset();
        edge_sample();
        @(negedge CLK_in);
        RESET = 1'b1;
        for (int i = 0; i < 5; i++) begin
            edge_sample();
            chk("held_reset", 4'd0);
        end
        @(negedge CLK_in);
        RESET = 1'b0;
        edge_sample();
        chk("held_release", 4'd1);
    endtask

    task automatic test_illegal();
        @(negedge CLK_in);
        force dut.count = 4'd12;
        #1 release dut.count;
        #1 chk("illegal_forced", 4'd12);
        edge_sample();
        chk("illegal_recover", 4'd0);
        for (int i = 1; i <= 10; i++) begin
            edge_sample();
            chk("illegal_sequence", 4'(i % 10));
        end
    endtask

    initial begin
        test_reset();
        test_wraps();
        test_mid_reset();
        test_short_pulse();
        test_held_reset();
        test_illegal();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
